// File: rtl/relogio_ajuste_ctrl_if.sv
// Button/current-time inputs and load bus outputs of the time-set controller.
// The slave modport is the controller's view; master is the driver side.
interface relogio_ajuste_ctrl_if;
   logic       btn_mode;
   logic       btn_inc;
   logic       btn_cancel;
   logic [1:0] cur_H1;
   logic [3:0] cur_H0;
   logic [3:0] cur_M1;
   logic [3:0] cur_M0;
   logic       LD;
   logic [1:0] H_in1;
   logic [3:0] H_in0;
   logic [3:0] M_in1;
   logic [3:0] M_in0;
   logic [3:0] edit_sel;
   logic       busy;

   modport slave (
      input  btn_mode, btn_inc, btn_cancel, cur_H1, cur_H0, cur_M1, cur_M0,
      output LD, H_in1, H_in0, M_in1, M_in0, edit_sel, busy
   );

   modport master (
      output btn_mode, btn_inc, btn_cancel, cur_H1, cur_H0, cur_M1, cur_M0,
      input  LD, H_in1, H_in0, M_in1, M_in0, edit_sel, busy
   );
endinterface

// File: rtl/relogio_ajuste_ctrl.sv
// Time-set controller: edits HH:MM digit by digit (H1, H0, M1, M0) and
// emits a one-cycle LD with the BCD load value on commit.
module relogio_ajuste_ctrl #(
   parameter int unsigned TIMEOUT = 30,
   parameter int unsigned TO_W    = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   relogio_ajuste_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      S_RUN,
      S_SET_H1,
      S_SET_H0,
      S_SET_M1,
      S_SET_M0,
      S_COMMIT
   } state_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   state_t          r_state, w_state_nx;
   logic [TO_W-1:0] r_to, w_to_nx;
   logic [1:0]      r_h1, w_h1_nx;
   logic [3:0]      r_h0, w_h0_nx;
   logic [3:0]      r_m1, w_m1_nx;
   logic [3:0]      r_m0, w_m0_nx;
   logic            r_ld, w_ld_nx;
   logic [3:0]      r_sel, w_sel_nx;
   logic            r_busy, w_busy_nx;
   logic            w_cap_h_ok, w_cap_m_ok;
   logic            w_editing;

   assign w_cap_h_ok = (bus.cur_H1 <= 2'd2) && (bus.cur_H0 <= 4'd9) &&
                       !((bus.cur_H1 == 2'd2) && (bus.cur_H0 > 4'd3));
   assign w_cap_m_ok = (bus.cur_M1 <= 4'd5) && (bus.cur_M0 <= 4'd9);
   assign w_editing  = (r_state == S_SET_H1) || (r_state == S_SET_H0) ||
                       (r_state == S_SET_M1) || (r_state == S_SET_M0);

   always_comb begin
      w_state_nx = r_state;
      w_to_nx    = '0;
      w_h1_nx    = r_h1;
      w_h0_nx    = r_h0;
      w_m1_nx    = r_m1;
      w_m0_nx    = r_m0;

      if (r_state == S_RUN) begin
         if (bus.btn_mode) begin
            w_state_nx = S_SET_H1;
            w_h1_nx    = w_cap_h_ok ? bus.cur_H1 : '0;
            w_h0_nx    = w_cap_h_ok ? bus.cur_H0 : '0;
            w_m1_nx    = w_cap_m_ok ? bus.cur_M1 : '0;
            w_m0_nx    = w_cap_m_ok ? bus.cur_M0 : '0;
         end
      end else if (r_state == S_COMMIT) begin
         w_state_nx = S_RUN;
      end else if (w_editing) begin
         // cancel > mode > inc > idle timeout; any accepted button leaves w_to_nx at 0
         if (bus.btn_cancel) begin
            w_state_nx = S_RUN;
         end else if (bus.btn_mode) begin
            case (r_state)
               S_SET_H1: w_state_nx = S_SET_H0;
               S_SET_H0: w_state_nx = S_SET_M1;
               S_SET_M1: w_state_nx = S_SET_M0;
               default:  w_state_nx = S_COMMIT;
            endcase
         end else if (bus.btn_inc) begin
            case (r_state)
               S_SET_H1: begin
                  if (r_h1 >= 2'd2) begin
                     w_h1_nx = '0;
                  end else begin
                     w_h1_nx = r_h1 + 2'd1;
                     if ((r_h1 == 2'd1) && (r_h0 > 4'd3))
                        w_h0_nx = 4'd3;
                  end
               end
               S_SET_H0: begin
                  if ((r_h0 >= 4'd9) || ((r_h1 == 2'd2) && (r_h0 >= 4'd3)))
                     w_h0_nx = '0;
                  else
                     w_h0_nx = r_h0 + 4'd1;
               end
               S_SET_M1: w_m1_nx = (r_m1 >= 4'd5) ? '0 : r_m1 + 4'd1;
               default:  w_m0_nx = (r_m0 >= 4'd9) ? '0 : r_m0 + 4'd1;
            endcase
         end else if (r_to == TO_LAST) begin
            w_state_nx = S_RUN;
         end else begin
            w_to_nx = r_to + TO_W'(1);
         end
      end else begin
         w_state_nx = S_RUN;
      end
   end

   always_comb begin
      w_ld_nx   = (w_state_nx == S_COMMIT);
      w_busy_nx = (w_state_nx != S_RUN);
      case (w_state_nx)
         S_SET_H1: w_sel_nx = 4'b1000;
         S_SET_H0: w_sel_nx = 4'b0100;
         S_SET_M1: w_sel_nx = 4'b0010;
         S_SET_M0: w_sel_nx = 4'b0001;
         default:  w_sel_nx = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_RUN;
         r_to    <= '0;
         r_h1    <= '0;
         r_h0    <= '0;
         r_m1    <= '0;
         r_m0    <= '0;
         r_ld    <= 1'b0;
         r_sel   <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_to    <= w_to_nx;
         r_h1    <= w_h1_nx;
         r_h0    <= w_h0_nx;
         r_m1    <= w_m1_nx;
         r_m0    <= w_m0_nx;
         r_ld    <= w_ld_nx;
         r_sel   <= w_sel_nx;
         r_busy  <= w_busy_nx;
      end
   end

   assign bus.LD       = r_ld;
   assign bus.H_in1    = r_h1;
   assign bus.H_in0    = r_h0;
   assign bus.M_in1    = r_m1;
   assign bus.M_in0    = r_m0;
   assign bus.edit_sel = r_sel;
   assign bus.busy     = r_busy;

endmodule

// File: tb/tb_relogio_ajuste_ctrl.sv
// Bench for relogio_ajuste_ctrl: capture table, hand-written edit/timeout/cancel/reset
// sequences and random button traffic, all against a time-arithmetic reference model.
module tb_relogio_ajuste_ctrl;
   localparam int TIMEOUT = 30;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   relogio_ajuste_ctrl_if u_if ();

   relogio_ajuste_ctrl #(.TIMEOUT(TIMEOUT), .TO_W(6)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // model: mode 0=idle, 1..4 = editing digit H1,H0,M1,M0, 5 = load cycle
   int m_mode, m_h, m_m, m_to;
   logic any_ld;

   typedef struct {
      int         h1, h0, m1, m0;
      logic [7:0] exp_h;
      logic [7:0] exp_m;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [19:0] exp_out();
      logic [3:0] sel;
      logic [1:0] h1;
      logic [3:0] h0, mm1, mm0;
      case (m_mode)
         1: sel = 4'b1000;
         2: sel = 4'b0100;
         3: sel = 4'b0010;
         4: sel = 4'b0001;
         default: sel = 4'b0000;
      endcase
      h1  = 2'(m_h / 10);
      h0  = 4'(m_h % 10);
      mm1 = 4'(m_m / 10);
      mm0 = 4'(m_m % 10);
      return {(m_mode == 5), h1, h0, mm1, mm0, sel, (m_mode != 0)};
   endfunction

   function automatic logic [19:0] act_out();
      return {u_if.LD, u_if.H_in1, u_if.H_in0, u_if.M_in1, u_if.M_in0, u_if.edit_sel, u_if.busy};
   endfunction

   function automatic logic [7:0] act_h();
      return {2'b00, u_if.H_in1, u_if.H_in0};
   endfunction

   function automatic logic [7:0] act_m();
      return {u_if.M_in1, u_if.M_in0};
   endfunction

   task automatic model_reset();
      m_mode = 0; m_h = 0; m_m = 0; m_to = 0;
   endtask

   task automatic model_inc();
      int d1, d0;
      case (m_mode)
         1: begin
            d1 = (m_h / 10 + 1) % 3;
            d0 = m_h % 10;
            if (d1 == 2 && d0 > 3) d0 = 3;
            m_h = d1 * 10 + d0;
         end
         2: begin
            d1 = m_h / 10;
            m_h = d1 * 10 + (m_h % 10 + 1) % ((d1 == 2) ? 4 : 10);
         end
         3: m_m = ((m_m / 10 + 1) % 6) * 10 + m_m % 10;
         default: m_m = (m_m / 10) * 10 + (m_m % 10 + 1) % 10;
      endcase
   endtask

   task automatic model_edge(input bit md, input bit inc, input bit cn);
      int ch, cm;
      if (m_mode == 0) begin
         if (md) begin
            ch = int'(u_if.cur_H1) * 10 + int'(u_if.cur_H0);
            cm = int'(u_if.cur_M1) * 10 + int'(u_if.cur_M0);
            m_h = (u_if.cur_H0 <= 9 && ch <= 23) ? ch : 0;
            m_m = (u_if.cur_M1 <= 5 && u_if.cur_M0 <= 9) ? cm : 0;
            m_mode = 1;
            m_to = 0;
         end
      end else if (m_mode == 5) begin
         m_mode = 0;
      end else begin
         if (cn) begin
            m_mode = 0; m_to = 0;
         end else if (md) begin
            m_mode = m_mode + 1; m_to = 0;
            if (m_mode == 5) m_to = 0;
         end else if (inc) begin
            model_inc(); m_to = 0;
         end else if (m_to == TIMEOUT - 1) begin
            m_mode = 0; m_to = 0;
         end else begin
            m_to = m_to + 1;
         end
      end
   endtask

   task automatic step(input bit md, input bit inc, input bit cn);
      u_if.btn_mode   = md;
      u_if.btn_inc    = inc;
      u_if.btn_cancel = cn;
      @(posedge clk);
      model_edge(md, inc, cn);
      @(negedge clk);
      chk("cycle", 32'(act_out()), 32'(exp_out()));
      any_ld = any_ld | u_if.LD;
   endtask

   task automatic set_cur(input int h1, input int h0, input int m1, input int m0);
      u_if.cur_H1 = 2'(h1);
      u_if.cur_H0 = 4'(h0);
      u_if.cur_M1 = 4'(m1);
      u_if.cur_M0 = 4'(m0);
   endtask

   vec_t vecs[8];
   int   nld;
   int   pm, pi, pc;

   initial begin
      vecs[0] = '{1, 2, 3, 4, 8'h12, 8'h34};
      vecs[1] = '{2, 3, 5, 9, 8'h23, 8'h59};
      vecs[2] = '{2, 4, 0, 0, 8'h00, 8'h00};
      vecs[3] = '{1, 9, 6, 0, 8'h19, 8'h00};
      vecs[4] = '{3, 0, 0, 0, 8'h00, 8'h00};
      vecs[5] = '{0, 15, 4, 5, 8'h00, 8'h45};
      vecs[6] = '{2, 0, 5, 10, 8'h20, 8'h00};
      vecs[7] = '{0, 9, 0, 9, 8'h09, 8'h09};

      u_if.btn_mode = 1'b0; u_if.btn_inc = 1'b0; u_if.btn_cancel = 1'b0;
      set_cur(1, 2, 3, 4);
      model_reset();
      any_ld = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", 32'(act_out()), 32'h0);
      reset = 1'b1;

      // capture sanitising table
      foreach (vecs[i]) begin
         set_cur(vecs[i].h1, vecs[i].h0, vecs[i].m1, vecs[i].m0);
         step(1, 0, 0);
         chk("cap_hours", 32'(act_h()), 32'(vecs[i].exp_h));
         chk("cap_minutes", 32'(act_m()), 32'(vecs[i].exp_m));
         chk("cap_sel", 32'(u_if.edit_sel), 32'h8);
         step(0, 0, 1);
         chk("cancel_busy", 32'(u_if.busy), 32'h0);
      end

      // plain commit of 12:34
      set_cur(1, 2, 3, 4);
      step(1, 0, 0);
      chk("enter_busy_ld", 32'({u_if.busy, u_if.LD}), 32'h2);
      nld = 0;
      for (int k = 0; k < 9; k++) begin
         step((k < 4) ? 1'b1 : 1'b0, 0, 0);
         if (u_if.LD) begin
            nld++;
            chk("load_value", 32'({act_h(), act_m()}), 32'h1234);
         end
      end
      chk("ld_count", 32'(nld), 32'd1);
      chk("after_commit", 32'({u_if.busy, u_if.edit_sel}), 32'h0);

      // digit wrap rules from 19:00
      set_cur(1, 9, 0, 0);
      step(1, 0, 0);
      step(0, 1, 0);
      chk("h1_clamp", 32'(act_h()), 32'h23);
      step(1, 0, 0);
      step(0, 1, 0);
      chk("h0_wrap3", 32'(act_h()), 32'h20);
      for (int k = 1; k <= 3; k++) begin
         step(0, 1, 0);
         chk("h0_count", 32'(act_h()), 32'(8'h20 + k));
      end
      step(0, 1, 0);
      chk("h0_wrap_again", 32'(act_h()), 32'h20);
      step(1, 0, 0);
      repeat (5) step(0, 1, 0);
      chk("m1_five", 32'(act_m()), 32'h50);
      step(0, 1, 0);
      chk("m1_wrap", 32'(act_m()), 32'h00);
      step(1, 0, 0);
      repeat (9) step(0, 1, 0);
      chk("m0_nine", 32'(act_m()), 32'h09);
      step(0, 1, 0);
      chk("m0_wrap", 32'(act_m()), 32'h00);
      step(1, 0, 0);
      chk("commit_ld", 32'({u_if.LD, act_h(), act_m()}), 32'h12000);
      step(0, 0, 0);
      chk("post_ld_hold", 32'({u_if.LD, u_if.busy, act_h(), act_m()}), 32'h02000);

      // idle timeout in SET_M1
      any_ld = 1'b0;
      set_cur(0, 8, 1, 5);
      repeat (3) step(1, 0, 0);
      repeat (TIMEOUT - 1) step(0, 0, 0);
      chk("to_not_yet", 32'(u_if.edit_sel), 32'h2);
      step(0, 0, 0);
      chk("to_abort", 32'({u_if.busy, u_if.edit_sel}), 32'h0);
      repeat (3) step(1, 0, 0);
      repeat (TIMEOUT - 1) step(0, 0, 0);
      step(0, 1, 0);
      chk("to_restart_m", 32'(act_m()), 32'h25);
      repeat (TIMEOUT - 1) step(0, 0, 0);
      chk("to_restarted", 32'(u_if.edit_sel), 32'h2);
      step(0, 0, 0);
      chk("to_abort2", 32'(u_if.busy), 32'h0);
      chk("to_no_ld", 32'(any_ld), 32'h0);

      // cancel beats mode in SET_M0
      repeat (4) step(1, 0, 0);
      chk("in_m0", 32'(u_if.edit_sel), 32'h1);
      step(1, 0, 1);
      chk("cancel_mode", 32'({u_if.LD, u_if.busy}), 32'h0);
      step(0, 0, 0);
      chk("cancel_no_ld", 32'(u_if.LD), 32'h0);

      // asynchronous reset during the load cycle
      repeat (5) step(1, 0, 0);
      chk("commit_before_rst", 32'(u_if.LD), 32'h1);
      #2 reset = 1'b0;
      #1 chk("rst_in_commit", 32'(act_out()), 32'h0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      step(0, 0, 0);

      // random traffic, varying button density so timeouts also occur
      for (int ph = 0; ph < 6; ph++) begin
         pm = (ph % 3 == 0) ? 25 : ((ph % 3 == 1) ? 8 : 1);
         pi = (ph % 3 == 2) ? 2 : 30;
         pc = (ph % 3 == 0) ? 5 : 1;
         for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0)
               set_cur($urandom_range(0, 3), $urandom_range(0, 15),
                       $urandom_range(0, 7), $urandom_range(0, 15));
            step($urandom_range(0, 99) < pm, $urandom_range(0, 99) < pi,
                 $urandom_range(0, 99) < pc);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
